// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: core request/response and data-memory signals of the load/store unit
interface lsu_rmw_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write_en, mem_addr, mem_data_in
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit with sub-word loads by lane extraction and sub-word stores by read-modify-write; optional LSU_MISALIGN_CHK_EN flags misaligned accesses
module lsu_rmw #(
  parameter int DATA_WIDTH    = 32,
  parameter int DMEM_SZ_IN_KB = 1
) (
  input logic       clk,
  input logic       arst_n,
  lsu_rmw_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DMEM_SZ_IN_KB * 1024);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_e;
  state_e                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, mdin_q, mdin_d;
  logic                    err_q, err_d;
  logic                    accept, mis;
  logic [4:0]              off;
  logic [DATA_WIDTH-1:0]   lane, ext, mask, merged;
  logic                    unused_addr;
`ifdef LSU_MISALIGN_CHK_EN
  assign mis = bus.req_size[1] ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
`else
  assign mis = 1'b0;
`endif
  assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH];
  assign accept      = bus.req_valid && state_q == IDLE;
  assign off         = size_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
  assign lane        = bus.mem_data_out >> off;
  assign ext         = size_q[1] ? bus.mem_data_out :
                       size_q[0] ? {{16{~uns_q & lane[15]}}, lane[15:0]} :
                                   {{24{~uns_q & lane[7]}}, lane[7:0]};
  assign mask        = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << off;
  assign merged      = (bus.mem_data_out & ~mask) | ((wdata_q << off) & mask);
  assign bus.req_ready    = state_q == IDLE;
  assign bus.rsp_valid    = state_q == RESP;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.mem_write_en = state_q == WRITE;
  assign bus.mem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_data_in  = mdin_q;
  // next state: capture request, extract load lane, merge sub-word store, hold response
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mdin_d  = mdin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        size_d  = bus.req_size;
        uns_d   = bus.req_unsigned;
        addr_d  = bus.req_addr[ADDR_WIDTH-1:0];
        wdata_d = bus.req_wdata;
        mdin_d  = bus.req_wdata;
        rdata_d = '0;
        err_d   = mis;
        state_d = mis ? RESP : !bus.req_we ? LOAD : bus.req_size[1] ? WRITE : MERGE;
      end
      LOAD: begin
        rdata_d = ext;
        state_d = RESP;
      end
      MERGE: begin
        mdin_d  = merged;
        state_d = WRITE;
      end
      WRITE: state_d = RESP;
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mdin_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mdin_q  <= mdin_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed self-checking bench for lsu_rmw with a word-wide memory model
module tb_lsu_rmw;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          writes = 0;
  int          wcyc = 0;
  int          acc_cyc = 0;
  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  lsu_rmw_if #(.DW(32), .AW(10)) bus ();
  lsu_rmw #(.DATA_WIDTH(32), .DMEM_SZ_IN_KB(1)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_data_out = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write_en) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_data_in;
      writes <= writes + 1;
      wcyc <= cyc;
    end else if (poke_en) mem[poke_idx] <= poke_val;
  end
  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = 1'b0;
    lat = 1; rd = 'x; er = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", bus.rsp_rdata); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", bus.rsp_err); end
    n_cmp++; if (bus.mem_write_en !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", bus.mem_write_en); end
    n_cmp++; if (bus.mem_addr !== 10'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_data_in !== 32'h0) begin n_err++; $display("FAIL reset_din got %h exp 0", bus.mem_data_in); end
    arst_n = 1'b1;
  endtask
  task automatic test_word_store_load;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = writes;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wst_lat got %0d exp 2", lat); end
    n_cmp++; if (writes - w0 !== 1) begin n_err++; $display("FAIL wst_writes got %0d exp 1", writes - w0); end
    n_cmp++; if (wcyc - acc_cyc + 1 !== 1) begin n_err++; $display("FAIL wst_wlat got %0d exp 1", wcyc - acc_cyc + 1); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem got %h exp deadbeef", mem[4]); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL wst_rdata got %h exp 0", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wld_lat got %0d exp 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wld_rdata got %h exp deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL wld_err got %b exp 0", er); end
  endtask
  task automatic test_subword_store;
    int lat; logic [31:0] rd; logic er; int w0;
    poke(8'd8, 32'h11223344);
    w0 = writes;
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h555555AA, lat, rd, er);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL bst_lat got %0d exp 3", lat); end
    n_cmp++; if (wcyc - acc_cyc + 1 !== 2) begin n_err++; $display("FAIL bst_wlat got %0d exp 2", wcyc - acc_cyc + 1); end
    n_cmp++; if (mem[8] !== 32'h1122AA44) begin n_err++; $display("FAIL bst_mem got %h exp 1122aa44", mem[8]); end
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, lat, rd, er);
    n_cmp++; if (mem[8] !== 32'hBEEFAA44) begin n_err++; $display("FAIL hst_mem got %h exp beefaa44", mem[8]); end
    n_cmp++; if (writes - w0 !== 2) begin n_err++; $display("FAIL sub_writes got %0d exp 2", writes - w0); end
  endtask
  task automatic test_loads;
    int lat; logic [31:0] rd; logic er;
    poke(8'd12, 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h00000001) begin n_err++; $display("FAIL lb30 got %h exp 00000001", rd); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL lb_lat got %0d exp 2", lat); end
    do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h0000007F) begin n_err++; $display("FAIL lb31 got %h exp 0000007f", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'hFFFFFFFF) begin n_err++; $display("FAIL lb32 got %h exp ffffffff", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h00000080) begin n_err++; $display("FAIL lbu33 got %h exp 00000080", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h000080FF) begin n_err++; $display("FAIL lhu32 got %h exp 000080ff", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh32 got %h exp ffff80ff", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h00007F01) begin n_err++; $display("FAIL lh30 got %h exp 00007f01", rd); end
    do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h80FF7F01) begin n_err++; $display("FAIL lsz3 got %h exp 80ff7f01", rd); end
  endtask
  task automatic test_stall;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = writes;
    bus.rsp_ready = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, lat, rd, er);
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b exp 1", bus.rsp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b exp 0", bus.req_ready); end
    n_cmp++; if (writes - w0 !== 1) begin n_err++; $display("FAIL stall_writes got %0d exp 1", writes - w0); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got %b exp 1", bus.req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL stall_load got %h exp 12345678", rd); end
  endtask
  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er; int w0;
    poke(8'd20, 32'hCAFEF00D);
    w0 = writes;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h52; bus.req_wdata = 32'h1234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_addr !== 10'h50) begin n_err++; $display("FAIL merge_addr got %h exp 050", bus.mem_addr); end
    arst_n = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_write_en !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_ctl got rdy=%b vld=%b we=%b exp 1 0 0", bus.req_ready, bus.rsp_valid, bus.mem_write_en); end
    n_cmp++; if (bus.mem_addr !== 10'h0 || bus.mem_data_in !== 32'h0)
      begin n_err++; $display("FAIL rst_mid_data got addr=%h din=%h exp 0 0", bus.mem_addr, bus.mem_data_in); end
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (writes - w0 !== 0) begin n_err++; $display("FAIL rst_mid_writes got %0d exp 0", writes - w0); end
    n_cmp++; if (mem[20] !== 32'hCAFEF00D) begin n_err++; $display("FAIL rst_mid_mem got %h exp cafef00d", mem[20]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL rst_mid_load got %h exp cafef00d", rd); end
  endtask
  task automatic test_misalign;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = writes;
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er);
`ifdef LSU_MISALIGN_CHK_EN
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL mis_lat got %0d exp 1", lat); end
    n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL mis_err got %b exp 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL mis_rdata got %h exp 0", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF, lat, rd, er);
    n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL mis_hst got err=%b lat=%0d exp 1 1", er, lat); end
    n_cmp++; if (mem[12] !== 32'h80FF7F01) begin n_err++; $display("FAIL mis_mem got %h exp 80ff7f01", mem[12]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_clear got err=%b rd=%h exp 0 deadbeef", er, rd); end
`else
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL mis_lat got %0d exp 2", lat); end
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL mis_err got %b exp 0", er); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_rdata got %h exp deadbeef", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h00007F01) begin n_err++; $display("FAIL mis_half got %h exp 00007f01", rd); end
`endif
    n_cmp++; if (writes - w0 !== 0) begin n_err++; $display("FAIL mis_writes got %0d exp 0", writes - w0); end
  endtask
  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'h44, 32'h000000C3, lat, rd, er);
    do_req(1'b1, 2'b00, 1'b0, 32'h47, 32'h0000003C, lat, rd, er);
    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h3C0000C3) begin n_err++; $display("FAIL b2b_rdata got %h exp 3c0000c3", rd); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL b2b_lat got %0d exp 2", lat); end
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset;
    test_word_store_load;
    test_subword_store;
    test_loads;
    test_stall;
    test_reset_mid;
    test_misalign;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store unit that initiates all core accesses to the word-wide data memory, which has combinational read, synchronous whole-word write and no byte enables. It accepts byte, halfword and word requests from the core pipeline over a valid/ready handshake. It performs sub-word loads by lane extraction with sign or zero extension. It performs sub-word stores by read-modify-write.

Parameters:
DATA_WIDTH, 32, memory word width; only 32 supported (4 byte lanes).
DMEM_SZ_IN_KB, 1, data memory size in KB.
ADDR_WIDTH, $clog2(DMEM_SZ_IN_KB*1024), localparam; byte address width on the memory side.

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address; bits above ADDR_WIDTH-1 ignored
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load result (0 for stores)
rsp_err  out  1  misaligned access (see Optional Feature)
mem_write_en  out  1  to memory write_en
mem_addr  out  ADDR_WIDTH  to memory addr
mem_data_in  out  32  to memory data_in
mem_data_out  in  32  from memory data_out (combinational read)

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_write_en=0; mem_addr=0; mem_data_in=0. Reset mid-operation aborts the access. A write is never issued in the reset cycle.
- Request is accepted on a cycle with req_valid && req_ready. The request is registered (we, size, unsigned, addr, wdata). req_ready=1 only in IDLE.
- mem_addr always equals the registered address with bits [1:0] forced to 0. mem_write_en is asserted only in WRITE.
- States:
  - IDLE: on accept, go to LOAD if load, WRITE if word store, MERGE if byte/half store.
  - LOAD: sample mem_data_out. Select lane by addr[1:0] for byte (addr[1]*16 for half). Extend per req_unsigned. Register into rsp_rdata. Go to RESP.
  - MERGE: sample mem_data_out. Replace the addressed byte (wdata[7:0]) or half (wdata[15:0]) lane. Register the merged word into mem_data_in. Go to WRITE.
  - WRITE: mem_write_en=1 for exactly one cycle. mem_data_in holds the merged word, or wdata for word stores. Go to RESP.
  - RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_ready, go to IDLE; the next request can be accepted the following cycle.
- Latency from accept cycle N to first rsp_valid: load N+2, word store N+2, sub-word store N+3 (write lands at rising edge ending cycle N+2).
- rsp_ready held low: the unit stalls in RESP indefinitely, with no further memory write.
- Word store: all four lanes written; mem_data_in = req_wdata.
- Load of a byte/half returns extended data; rsp_rdata upper bits follow the extension rule exactly.
- req_valid changes while req_ready=0 are ignored.

Optional Feature:
LSU_MISALIGN_CHK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, is a misaligned access. It goes IDLE→RESP directly with rsp_err=1 and rsp_rdata=0, so the response appears at N+1. No memory write occurs.
- Undefined: rsp_err is tied 0. Misaligned low bits are ignored: half uses addr[1] only; word uses addr[1:0]=0.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → mem_write_en pulses once at N+1; load returns rsp_rdata=0xDEADBEEF at N+2.
- Memory word at 0x20 = 0x11223344; byte store 0xAA to 0x21 → memory word becomes 0x1122AA44; rsp_valid at N+3.
- Word at 0x30 = 0x80FF7F01; signed byte loads from 0x30, 0x31, 0x32 → 0x00000001, 0x0000007F, 0xFFFFFFFF. Unsigned halfword load from 0x32 → 0x000080FF; signed → 0xFFFF80FF.
- Hold rsp_ready=0 for 5 cycles after a store → rsp_valid stays 1, req_ready=0, exactly one mem_write_en pulse; accept a new request the cycle after rsp_ready=1.
- Assert arst_n=0 while in MERGE of a halfword store → no write occurs, outputs return to reset values, memory word unchanged.
- With LSU_MISALIGN_CHK_EN: word load from 0x13 → rsp_err=1, rsp_rdata=0 at N+1, mem_write_en never asserted. Without the macro: the same load returns the word at 0x10.
